ysyx_inst_encoder: RTL and testbench

- Inverse of the NPC immediate extender: packs a (kind, rd, rs1, imm) request into a 32-bit RV32I instruction word.
- Covers the same five formats the decoder side supports: LUI, AUIPC, ADDI, JAL, JALR.
- Used in the NPC bench and self-test path to generate instruction streams for the IFU or an instruction memory.
- valid/ready on both sides; 2-entry output FIFO; running count of emitted instructions.

---
 rtl/ysyx_inst_encoder.sv | 112 +++++++++++
 tb/tb_ysyx_inst_encoder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_inst_encoder.sv
// Packs (kind, rd, rs1, imm) requests into RV32I words (LUI/AUIPC/ADDI/JAL/JALR) behind a small output FIFO.
// Optional immediate range check enabled by defining YSYX_INST_ENCODER_RANGECHK_EN.
module ysyx_inst_encoder #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_kind,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             err,
    output logic [CNT_W-1:0] enc_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [2:0] KIND_LUI   = 3'd0;
    localparam logic [2:0] KIND_AUIPC = 3'd1;
    localparam logic [2:0] KIND_ADDI  = 3'd2;
    localparam logic [2:0] KIND_JAL   = 3'd3;
    localparam logic [2:0] KIND_JALR  = 3'd4;

    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;

    logic [31:0] enc_word;
    logic        kind_legal;
    logic        range_ok;
    logic        accept;
    logic        push;
    logic        pop;

    always_comb begin
        enc_word   = 32'd0;
        kind_legal = 1'b1;
        case (in_kind)
            KIND_LUI:   enc_word = {in_imm[31:12], in_rd, 7'b0110111};
            KIND_AUIPC: enc_word = {in_imm[31:12], in_rd, 7'b0010111};
            KIND_ADDI:  enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
            KIND_JALR:  enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
            KIND_JAL:   enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                    in_rd, 7'b1101111};
            default:    kind_legal = 1'b0;
        endcase
    end

`ifdef YSYX_INST_ENCODER_RANGECHK_EN
    // Reject immediates that the chosen format would silently truncate.
    always_comb begin
        range_ok = 1'b1;
        case (in_kind)
            KIND_LUI, KIND_AUIPC: range_ok = (in_imm[11:0] == 12'd0);
            KIND_ADDI, KIND_JALR: range_ok = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
            KIND_JAL:             range_ok = ((in_imm[31:20] == '0) || (in_imm[31:20] == '1))
                                             && !in_imm[0];
            default:              range_ok = 1'b1;
        endcase
    end
`else
    assign range_ok = 1'b1;
`endif

    // in_ready looks only at occupancy, never at out_ready, so a full FIFO stalls the producer.
    assign in_ready  = !rst && (occ < OCC_W'(FIFO_DEPTH));
    assign accept    = in_valid && in_ready;
    assign push      = accept && kind_legal && range_ok;
    assign out_valid = (occ != '0);
    assign pop       = out_valid && out_ready;
    assign out_inst  = out_valid ? mem[rd_ptr] : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            err       <= 1'b0;
            enc_count <= '0;
        end else begin
            err <= accept && !push;
            if (push) begin
                wr_ptr    <= wr_ptr + PTR_W'(1);
                enc_count <= enc_count + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset: out_inst is gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enc_word;
        end
    end

endmodule

// File: tb/tb_ysyx_inst_encoder.sv
// Self-checking bench for ysyx_inst_encoder: directed scenarios plus a randomized stream
// scored against a queue-based reference model.
module tb_ysyx_inst_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_kind;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        err;
    logic [31:0] enc_count;

    int tests  = 0;
    int failed = 0;

    ysyx_inst_encoder #(.FIFO_DEPTH(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .err(err), .enc_count(enc_count)
    );

    always #5 clk = ~clk;

    // Reference encoding built from field arithmetic on the instruction layout.
    function automatic logic [31:0] ref_enc(input int kind, input logic [31:0] rd,
                                            input logic [31:0] rs1, input logic [31:0] imm);
        logic [31:0] w;
        w = (rd & 32'h1F) * 32'd128;
        case (kind)
            0: w = w + (imm & 32'hFFFFF000) + 32'h37;
            1: w = w + (imm & 32'hFFFFF000) + 32'h17;
            2: w = w + (imm & 32'hFFF) * 32'h100000 + (rs1 & 32'h1F) * 32'h8000 + 32'h13;
            4: w = w + (imm & 32'hFFF) * 32'h100000 + (rs1 & 32'h1F) * 32'h8000 + 32'h67;
            3: w = w + ((imm / 32'h100000) % 2) * 32'h80000000
                     + ((imm / 2) % 1024) * 32'h200000
                     + ((imm / 2048) % 2) * 32'h100000
                     + ((imm / 4096) % 256) * 32'h1000 + 32'h6F;
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    function automatic bit ref_pushes(input int kind, input logic [31:0] imm);
        int simm;
        simm = $signed(imm);
        if (kind > 4) return 1'b0;
`ifdef YSYX_INST_ENCODER_RANGECHK_EN
        case (kind)
            0, 1: return (imm % 4096) == 0;
            2, 4: return (simm >= -2048) && (simm <= 2047);
            3:    return (simm >= -1048576) && (simm <= 1048575) && ((imm % 2) == 0);
            default: return 1'b0;
        endcase
`else
        return 1'b1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int kind, input int rd, input int rs1,
                         input logic [31:0] imm);
        in_valid = v;
        in_kind  = 3'(kind);
        in_rd    = 5'(rd);
        in_rs1   = 5'(rs1);
        in_imm   = imm;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 32'd0);
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 32'd0);
        out_ready = 1'b1;
        rst = 1'b1;
        tick();
        tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        tests++; if (out_valid !== 1'b0 || out_inst !== 32'd0) begin failed++; $display("FAIL reset_out got v=%b inst=%h exp 0/0", out_valid, out_inst); end
        tests++; if (enc_count !== 32'd0 || err !== 1'b0) begin failed++; $display("FAIL reset_cnt_err got cnt=%0d err=%b exp 0/0", enc_count, err); end
        rst = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL reset_release_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_directed();
        do_reset();
        out_ready = 1'b1;
        drive(1, 0, 5, 0, 32'h12345000);
        tick();
        drive(0, 0, 0, 0, 32'd0);
        tests++; if (out_valid !== 1'b1 || out_inst !== 32'h123452B7) begin failed++; $display("FAIL lui got v=%b inst=%h exp 1/123452b7", out_valid, out_inst); end
        tests++; if (enc_count !== 32'd1) begin failed++; $display("FAIL lui_count got %0d exp 1", enc_count); end
        tick();
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL lui_drain got %b exp 0", out_valid); end
        drive(1, 2, 1, 2, 32'hFFFFFFFF);
        tick();
        tests++; if (out_inst !== 32'hFFF10093) begin failed++; $display("FAIL addi got %h exp fff10093", out_inst); end
        drive(1, 3, 1, 0, 32'd8);
        tick();
        drive(0, 0, 0, 0, 32'd0);
        tests++; if (out_valid !== 1'b1 || out_inst !== 32'h008000EF) begin failed++; $display("FAIL jal got v=%b inst=%h exp 1/008000ef", out_valid, out_inst); end
        tests++; if (enc_count !== 32'd3) begin failed++; $display("FAIL jal_count got %0d exp 3", enc_count); end
        drive(1, 1, 31, 0, 32'hABCDE000);
        tick();
        drive(0, 0, 0, 0, 32'd0);
        tests++; if (out_inst !== 32'hABCDEF97) begin failed++; $display("FAIL auipc got %h exp abcdef97", out_inst); end
        drive(1, 4, 10, 3, 32'hFFFFF800);
        tick();
        drive(0, 0, 0, 0, 32'd0);
        tests++; if (out_inst !== 32'h80018567) begin failed++; $display("FAIL jalr got %h exp 80018567", out_inst); end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0;
        drive(1, 0, 1, 0, 32'h11111000);
        tick();
        drive(1, 0, 2, 0, 32'h22222000);
        tick();
        drive(1, 0, 3, 0, 32'h33333000);
        tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL bp_full_ready got %b exp 0", in_ready); end
        tick();
        tests++; if (in_ready !== 1'b0 || out_inst !== 32'h111110B7) begin failed++; $display("FAIL bp_hold got rdy=%b inst=%h exp 0/111110b7", in_ready, out_inst); end
        out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL bp_no_passthru got %b exp 0", in_ready); end
        tick();
        tests++; if (out_inst !== 32'h22222137 || in_ready !== 1'b1) begin failed++; $display("FAIL bp_second got inst=%h rdy=%b exp 22222137/1", out_inst, in_ready); end
        tick();
        drive(0, 0, 0, 0, 32'd0);
        tests++; if (out_inst !== 32'h333331B7 || enc_count !== 32'd3) begin failed++; $display("FAIL bp_third got inst=%h cnt=%0d exp 333331b7/3", out_inst, enc_count); end
        tick();
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL bp_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_illegal();
        do_reset();
        out_ready = 1'b1;
        drive(1, 6, 7, 7, 32'h12345678);
        #1;
        tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL illegal_ready got %b exp 1", in_ready); end
        tick();
        drive(0, 0, 0, 0, 32'd0);
        tests++; if (err !== 1'b1 || out_valid !== 1'b0 || enc_count !== 32'd0) begin failed++; $display("FAIL illegal_drop got err=%b v=%b cnt=%0d exp 1/0/0", err, out_valid, enc_count); end
        tick();
        tests++; if (err !== 1'b0) begin failed++; $display("FAIL illegal_pulse got %b exp 0", err); end
    endtask

    task automatic test_range();
        do_reset();
        out_ready = 1'b1;
        drive(1, 2, 0, 0, 32'h00000800);
        tick();
        drive(0, 0, 0, 0, 32'd0);
`ifdef YSYX_INST_ENCODER_RANGECHK_EN
        tests++; if (err !== 1'b1 || out_valid !== 1'b0) begin failed++; $display("FAIL range_drop got err=%b v=%b exp 1/0", err, out_valid); end
`else
        tests++; if (err !== 1'b0 || out_inst !== 32'h80000013) begin failed++; $display("FAIL range_trunc got err=%b inst=%h exp 0/80000013", err, out_inst); end
`endif
        tick();
        drive(1, 2, 0, 0, 32'h000007FF);
        tick();
        drive(0, 0, 0, 0, 32'd0);
        tests++; if (err !== 1'b0 || out_inst !== 32'h7FF00013) begin failed++; $display("FAIL range_edge got err=%b inst=%h exp 0/7ff00013", err, out_inst); end
        tick();
    endtask

    task automatic test_reset_when_full();
        do_reset();
        out_ready = 1'b0;
        drive(1, 0, 4, 0, 32'h44444000);
        tick();
        drive(1, 0, 5, 0, 32'h55555000);
        tick();
        drive(0, 0, 0, 0, 32'd0);
        tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin failed++; $display("FAIL full_pre got rdy=%b v=%b exp 0/1", in_ready, out_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || out_inst !== 32'd0 || in_ready !== 1'b1) begin failed++; $display("FAIL full_rst got v=%b inst=%h rdy=%b exp 0/0/1", out_valid, out_inst, in_ready); end
        tests++; if (enc_count !== 32'd0 || err !== 1'b0) begin failed++; $display("FAIL full_rst_cnt got cnt=%0d err=%b exp 0/0", enc_count, err); end
        out_ready = 1'b1;
        tick();
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL full_rst_stale got %b exp 0", out_valid); end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] cnt;
        bit          err_exp;
        bit          exp_ready;
        int          kind;
        int          sel;
        logic [31:0] imm;
        do_reset();
        cnt = 32'd0;
        err_exp = 1'b0;
        for (int c = 0; c < 600; c++) begin
            tests++; if (out_valid !== (q.size() != 0)) begin failed++; $display("FAIL rnd_valid cyc %0d got %b exp %b", c, out_valid, q.size() != 0); end
            tests++; if (out_inst !== ((q.size() != 0) ? q[0] : 32'd0)) begin failed++; $display("FAIL rnd_inst cyc %0d got %h exp %h", c, out_inst, (q.size() != 0) ? q[0] : 32'd0); end
            tests++; if (enc_count !== cnt || err !== err_exp) begin failed++; $display("FAIL rnd_cnt_err cyc %0d got cnt=%0d err=%b exp %0d/%b", c, enc_count, err, cnt, err_exp); end
            kind = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
            sel  = $urandom_range(0, 3);
            case (sel)
                0: imm = $urandom;
                1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                2: imm = $urandom & 32'hFFFFF000;
                default: imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & 32'hFFFFFFFE;
            endcase
            drive($urandom_range(0, 3) != 0, kind, $urandom_range(0, 31), $urandom_range(0, 31), imm);
            out_ready = ($urandom_range(0, 2) != 0);
            exp_ready = (q.size() < 2);
            #1;
            tests++; if (in_ready !== exp_ready) begin failed++; $display("FAIL rnd_ready cyc %0d got %b exp %b", c, in_ready, exp_ready); end
            err_exp = 1'b0;
            if (out_ready && q.size() != 0) void'(q.pop_front());
            if (in_valid && exp_ready) begin
                if (ref_pushes(kind, imm)) begin
                    q.push_back(ref_enc(kind, 32'(in_rd), 32'(in_rs1), imm));
                    cnt = cnt + 32'd1;
                end else begin
                    err_exp = 1'b1;
                end
            end
            tick();
        end
        drive(0, 0, 0, 0, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        drive(0, 0, 0, 0, 32'd0);
        test_reset();
        test_directed();
        test_back_to_back();
        test_illegal();
        test_range();
        test_reset_when_full();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
